eeprom_seq: RTL
===============

Name: eeprom_seq

Overview:
- Wishbone master that sequences the Wishbone-SPI interface to perform complete M25LC020A byte read/write transactions.
- A client issues a one-cycle request (address, data, direction). The block programs the baud register, then emits the instruction, address and data frames, polls WIP after writes, and returns read data.
- Replaces hand-sequenced bus traffic to the SPI core; sits between system logic and the SPI interface's Wishbone slave port.

Parameters:
BAUD, 32'h0000_0203, value written to baud register (addr 0x20) after reset
POLL_MAX, 255, max status polls per write before error
ACK_TIMEOUT, 1023, clocks to wait for m_ack or spi_dint before abort

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request strobe; accepted when req_ready=1
req_ready  out  1  high in IDLE only
req_we  in  1  1=write byte, 0=read byte
req_addr  in  8  EEPROM byte address
req_wdata  in  8  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_rdata  out  8  read byte (0 for writes), valid with rsp_valid
rsp_err  out  1  timeout flag, valid with rsp_valid
m_addr  out  32  Wishbone address to SPI interface
m_dout  out  32  Wishbone write data
m_we  out  1  Wishbone write enable
m_stb  out  1  Wishbone strobe
m_cyc  out  1  Wishbone cycle
m_din  in  32  Wishbone read data
m_ack  in  1  Wishbone acknowledge
spi_dint  in  1  SPI receive-data-available

Behaviour:
- Reset (rst=0, async): all outputs 0 (m_addr, m_dout, rsp_rdata = 0; req_ready=0); state INIT; counters cleared. A bus cycle in flight is dropped immediately (stb/cyc low). After release, INIT reprograms baud.
- SPI data-register word (addr 0x10): [7:0] byte, [10:8] frame code. 1=open frame (SS low); 0=middle byte; 2=last byte, then release SS; 3=single-byte frame; 6=receive one byte and end frame. Read of 0x10 returns received byte in [7:0].
- Bus cycle: addr/dout/we/stb/cyc registered together. Hold until m_ack sampled high. Deassert stb/cyc/we on the next edge. At least one idle clock between cycles. Read data is captured on the ack edge.
- States: INIT, IDLE, ISSUE, WAIT_ACK, GAP, WAIT_DINT, CHECK, DONE.
  - INIT: one write of BAUD to 0x20, then IDLE.
  - IDLE: req_ready=1. On req_valid, latch we/addr/wdata, clear step index, go to ISSUE. req_ready drops the cycle after acceptance.
- Write step list:
  - 0x306 (WREN)
  - 0x102 (WRITE)
  - 0x000|addr
  - 0x200|wdata
  - poll loop: 0x105 (RDSR), then 0x600, wait spi_dint, read 0x10.
  - In CHECK: if m_din[0]=1 (WIP) and polls<POLL_MAX, increment poll count and repeat the loop. Else go to DONE.
- Read step list:
  - 0x103 (READ)
  - 0x000|addr
  - 0x600, wait spi_dint, read 0x10
  - rsp_rdata=m_din[7:0], go to DONE.
- WAIT_DINT: entered after a 0x600 write's ack. Waits for spi_dint=1 (level). If spi_dint is already high on entry, proceed the next clock.
- DONE: rsp_valid=1 for exactly one clock; rsp_err=1 if poll count reached POLL_MAX with WIP still 1. Return to IDLE.
- Timeout: a counter runs in WAIT_ACK/WAIT_DINT and reloads on each new cycle. When it reaches ACK_TIMEOUT, drop stb/cyc, go to DONE with rsp_err=1, rsp_rdata=0.
- req_valid while not in IDLE is ignored (not queued).
- Poll counter is 8 bits, saturating, cleared on each accepted request.

Test Plan:
- Reset release, bus model acks after 2 clocks -> first cycle is write addr 0x20 data 0x203. req_ready rises after its ack; rsp_valid stays 0.
- Write req addr 0xFE data 0xD3, status reads 0x01,0x01,0x00 -> write sequence 0x306,0x102,0x0FE,0x2D3. Exactly 3 poll iterations (0x105,0x600,read each). Then one rsp_valid, rsp_err=0, rsp_rdata=0.
- Read req addr 0xFE with EEPROM model holding 0xD3 -> writes 0x103,0x0FE,0x600. After spi_dint, a read of 0x10. rsp_valid with rsp_rdata=0xD3, rsp_err=0.
- Bus model never acks the 0x102 write -> stb/cyc drop after ACK_TIMEOUT+1 clocks; rsp_valid with rsp_err=1. Next request proceeds normally.
- Status stuck 0x01, POLL_MAX=3 -> 4 status reads total, then rsp_err=1 pulse.
- rst asserted during a WAIT_ACK of a write -> m_stb/m_cyc/rsp_valid 0 immediately. After release, the baud write reissues and no rsp_valid appears for the aborted request.

Source files
------------

// File: rtl/eeprom_seq.sv
// Wishbone master that turns one-cycle byte read/write requests into the
// complete M25LC020A command sequence on the Wishbone-SPI core.
module eeprom_seq #(
    parameter logic [31:0] BAUD        = 32'h0000_0203,
    parameter int          POLL_MAX    = 255,
    parameter int          ACK_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [7:0]  req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] m_addr,
    output logic [31:0] m_dout,
    output logic        m_we,
    output logic        m_stb,
    output logic        m_cyc,
    input  logic [31:0] m_din,
    input  logic        m_ack,
    input  logic        spi_dint
);

    typedef enum logic [2:0] {
        INIT, IDLE, ISSUE, WAIT_ACK, GAP, WAIT_DINT, CHECK, DONE
    } state_t;

    localparam logic [31:0]    DATA_REG  = 32'h0000_0010;
    localparam logic [31:0]    BAUD_REG  = 32'h0000_0020;
    localparam int             TMO_W     = $clog2(ACK_TIMEOUT + 2);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT);
    localparam logic [7:0]     POLL_LAST = 8'(POLL_MAX);
    localparam logic [2:0]     POLL_STEP = 3'd4;

    state_t            state_reg, state_next;
    logic              boot_reg, boot_next;
    logic              op_we_reg, op_we_next;
    logic [7:0]        op_addr_reg, op_addr_next;
    logic [7:0]        op_wdata_reg, op_wdata_next;
    logic [2:0]        step_reg, step_next;
    logic [7:0]        poll_reg, poll_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;
    logic [7:0]        din_reg, din_next;
    logic [7:0]        rdata_reg, rdata_next;
    logic              err_reg, err_next;
    logic [31:0]       addr_reg, addr_next;
    logic [31:0]       dout_reg, dout_next;
    logic              we_reg, we_next;
    logic              stb_reg, stb_next;

    logic [10:0]       step_word;
    logic              step_read;
    logic              step_dint;
    logic              step_last;
    logic              unused_din;

    assign unused_din = ^m_din[31:8];

    // Current step of the command list: frame word, or a read of the data register.
    always_comb begin
        step_word = 11'h000;
        step_read = 1'b0;
        step_dint = 1'b0;
        step_last = 1'b0;
        if (op_we_reg) begin
            case (step_reg)
                3'd0: step_word = 11'h306;
                3'd1: step_word = 11'h102;
                3'd2: step_word = {3'h0, op_addr_reg};
                3'd3: step_word = {3'h2, op_wdata_reg};
                3'd4: step_word = 11'h105;
                3'd5: begin
                    step_word = 11'h600;
                    step_dint = 1'b1;
                end
                default: begin
                    step_read = 1'b1;
                    step_last = 1'b1;
                end
            endcase
        end else begin
            case (step_reg)
                3'd0: step_word = 11'h103;
                3'd1: step_word = {3'h0, op_addr_reg};
                3'd2: begin
                    step_word = 11'h600;
                    step_dint = 1'b1;
                end
                default: begin
                    step_read = 1'b1;
                    step_last = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        state_next    = state_reg;
        boot_next     = boot_reg;
        op_we_next    = op_we_reg;
        op_addr_next  = op_addr_reg;
        op_wdata_next = op_wdata_reg;
        step_next     = step_reg;
        poll_next     = poll_reg;
        tmo_next      = tmo_reg;
        din_next      = din_reg;
        rdata_next    = rdata_reg;
        err_next      = err_reg;
        addr_next     = addr_reg;
        dout_next     = dout_reg;
        we_next       = we_reg;
        stb_next      = stb_reg;

        case (state_reg)
            INIT: begin
                addr_next  = BAUD_REG;
                dout_next  = BAUD;
                we_next    = 1'b1;
                stb_next   = 1'b1;
                tmo_next   = '0;
                state_next = WAIT_ACK;
            end
            IDLE: begin
                if (req_valid) begin
                    op_we_next    = req_we;
                    op_addr_next  = req_addr;
                    op_wdata_next = req_wdata;
                    step_next     = 3'd0;
                    poll_next     = 8'd0;
                    err_next      = 1'b0;
                    rdata_next    = 8'd0;
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                addr_next  = DATA_REG;
                dout_next  = step_read ? 32'd0 : {21'd0, step_word};
                we_next    = ~step_read;
                stb_next   = 1'b1;
                tmo_next   = '0;
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (m_ack) begin
                    stb_next = 1'b0;
                    we_next  = 1'b0;
                    if (boot_reg) begin
                        boot_next  = 1'b0;
                        state_next = IDLE;
                    end else if (step_dint) begin
                        tmo_next   = '0;
                        state_next = WAIT_DINT;
                    end else if (step_last) begin
                        if (op_we_reg) begin
                            din_next   = m_din[7:0];
                            state_next = CHECK;
                        end else begin
                            rdata_next = m_din[7:0];
                            state_next = DONE;
                        end
                    end else begin
                        step_next  = step_reg + 3'd1;
                        state_next = GAP;
                    end
                end else if (tmo_reg == TMO_LAST) begin
                    stb_next = 1'b0;
                    we_next  = 1'b0;
                    // A dead baud write is retried rather than reported to a client.
                    if (boot_reg) begin
                        state_next = INIT;
                    end else begin
                        err_next   = 1'b1;
                        rdata_next = 8'd0;
                        state_next = DONE;
                    end
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            GAP: state_next = ISSUE;
            WAIT_DINT: begin
                if (spi_dint) begin
                    step_next  = step_reg + 3'd1;
                    state_next = ISSUE;
                end else if (tmo_reg == TMO_LAST) begin
                    err_next   = 1'b1;
                    rdata_next = 8'd0;
                    state_next = DONE;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            CHECK: begin
                if (din_reg[0] && (poll_reg < POLL_LAST)) begin
                    poll_next  = poll_reg + 8'd1;
                    step_next  = POLL_STEP;
                    state_next = ISSUE;
                end else begin
                    err_next   = din_reg[0];
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= INIT;
            boot_reg     <= 1'b1;
            op_we_reg    <= 1'b0;
            op_addr_reg  <= 8'd0;
            op_wdata_reg <= 8'd0;
            step_reg     <= 3'd0;
            poll_reg     <= 8'd0;
            tmo_reg      <= '0;
            din_reg      <= 8'd0;
            rdata_reg    <= 8'd0;
            err_reg      <= 1'b0;
            addr_reg     <= 32'd0;
            dout_reg     <= 32'd0;
            we_reg       <= 1'b0;
            stb_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            boot_reg     <= boot_next;
            op_we_reg    <= op_we_next;
            op_addr_reg  <= op_addr_next;
            op_wdata_reg <= op_wdata_next;
            step_reg     <= step_next;
            poll_reg     <= poll_next;
            tmo_reg      <= tmo_next;
            din_reg      <= din_next;
            rdata_reg    <= rdata_next;
            err_reg      <= err_next;
            addr_reg     <= addr_next;
            dout_reg     <= dout_next;
            we_reg       <= we_next;
            stb_reg      <= stb_next;
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = (state_reg == DONE);
    assign rsp_rdata = rdata_reg;
    assign rsp_err   = err_reg & (state_reg == DONE);
    assign m_addr    = addr_reg;
    assign m_dout    = dout_reg;
    assign m_we      = we_reg;
    assign m_stb     = stb_reg;
    assign m_cyc     = stb_reg;

endmodule
